// File: rtl/ext_pipe_if.sv
// Handshake bundle for the immediate-extension stage: decode-side input,
// execute-side output, squash control and the sticky error flag.
interface ext_pipe_if #(
  parameter int IMM_W  = 16,
  parameter int DATA_W = 32
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  logic [2:0]        in_op;
  logic [DATA_W-1:0] in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_ext;
  logic              out_err;
  logic              err_sticky;

  modport slave (
    input  flush, in_valid, in_imm, in_op, in_pc, out_ready,
    output in_ready, out_valid, out_ext, out_err, err_sticky
  );

  modport master (
    output flush, in_valid, in_imm, in_op, in_pc, out_ready,
    input  in_ready, out_valid, out_ext, out_err, err_sticky
  );
endinterface

// File: rtl/ext_pipe.sv
// Registered immediate-extension stage between decode and execute, with a
// one-entry skid behind the output register for full-rate backpressure.
module ext_pipe #(
  parameter int IMM_W   = 16,
  parameter int DATA_W  = 32,
  parameter int SHIFT_B = 2
) (
  input  logic     clk,
  input  logic     reset,
  ext_pipe_if.slave bus
);

  // Result packed as {err, value}; illegal opcodes yield zero with err set.
  function automatic logic [DATA_W:0] f_extend(
    input logic [IMM_W-1:0]  imm,
    input logic [2:0]        op,
    input logic [DATA_W-1:0] pc
  );
    logic [DATA_W-1:0] sext;
    logic [DATA_W:0]   res;
    sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    case (op)
      3'd0:    res = {1'b0, sext};
      3'd1:    res = {1'b0, {(DATA_W-IMM_W){1'b0}}, imm};
      3'd2:    res = {1'b0, imm, {(DATA_W-IMM_W){1'b0}}};
      3'd3:    res = {1'b0, sext << SHIFT_B};
      3'd4:    res = {1'b0, pc + DATA_W'(3'd4) + (sext << SHIFT_B)};
      default: res = {1'b1, {DATA_W{1'b0}}};
    endcase
    return res;
  endfunction

  logic              r_main_valid;
  logic [DATA_W-1:0] r_main_ext;
  logic              r_main_err;
  logic              r_skid_valid;
  logic [DATA_W-1:0] r_skid_ext;
  logic              r_skid_err;
  logic              r_err_sticky;

  logic [DATA_W:0]   w_res;
  logic              w_accept;
  logic              w_xfer;

  assign w_res    = f_extend(bus.in_imm, bus.in_op, bus.in_pc);
  assign w_accept = bus.in_valid & ~r_skid_valid;
  assign w_xfer   = r_main_valid & bus.out_ready;

  // Output register, skid entry and sticky error flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main_valid <= 1'b0;
      r_main_ext   <= {DATA_W{1'b0}};
      r_main_err   <= 1'b0;
      r_skid_valid <= 1'b0;
      r_skid_ext   <= {DATA_W{1'b0}};
      r_skid_err   <= 1'b0;
      r_err_sticky <= 1'b0;
    end else if (bus.flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else begin
      if (w_accept && w_res[DATA_W]) begin
        r_err_sticky <= 1'b1;
      end
      if (!r_main_valid || w_xfer) begin
        if (r_skid_valid) begin
          r_main_valid <= 1'b1;
          r_main_ext   <= r_skid_ext;
          r_main_err   <= r_skid_err;
          r_skid_valid <= 1'b0;
        end else if (w_accept) begin
          r_main_valid <= 1'b1;
          r_main_ext   <= w_res[DATA_W-1:0];
          r_main_err   <= w_res[DATA_W];
        end else begin
          r_main_valid <= 1'b0;
        end
      end else if (w_accept) begin
        // Output is stalled: park the new entry so in_ready can drop next cycle.
        r_skid_valid <= 1'b1;
        r_skid_ext   <= w_res[DATA_W-1:0];
        r_skid_err   <= w_res[DATA_W];
      end
    end
  end

  assign bus.in_ready   = ~r_skid_valid;
  assign bus.out_valid  = r_main_valid;
  assign bus.out_ext    = r_main_ext;
  assign bus.out_err    = r_main_err;
  assign bus.err_sticky = r_err_sticky;

endmodule

// File: tb/tb_ext_pipe.sv
// Self-checking bench for ext_pipe: directed scenarios then randomized traffic,
// all checked against a queue-based occupancy/ordering model.
module tb_ext_pipe;
  localparam int IW = 16;
  localparam int DW = 32;
  localparam int SB = 2;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;
  logic [DW:0] q[$];
  logic sticky;

  ext_pipe_if #(.IMM_W(IW), .DATA_W(DW)) bus();

  ext_pipe #(.IMM_W(IW), .DATA_W(DW), .SHIFT_B(SB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected {err, value} from plain signed arithmetic, reduced modulo 2^DW.
  function automatic logic [DW:0] ref_ext(input logic [IW-1:0] imm, input logic [2:0] op,
                                          input logic [DW-1:0] pc);
    longint s;
    longint u;
    longint r;
    u = longint'(imm);
    s = imm[IW-1] ? u - (longint'(1) << IW) : u;
    case (op)
      3'd0: r = s;
      3'd1: r = u;
      3'd2: r = u * (longint'(1) << (DW - IW));
      3'd3: r = s * (longint'(1) << SB);
      3'd4: r = longint'(pc) + 4 + s * (longint'(1) << SB);
      default: return {1'b1, {DW{1'b0}}};
    endcase
    return {1'b0, r[DW-1:0]};
  endfunction

  task automatic cycle(input logic v, input logic [IW-1:0] imm, input logic [2:0] op,
                       input logic [DW-1:0] pc, input logic ordy, input logic fl);
    logic acc;
    logic xf;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_imm    = imm;
    bus.in_op     = op;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    bus.flush     = fl;
    #1;
    chk("in_ready", {63'd0, bus.in_ready}, {63'd0, q.size() < 2});
    chk("out_valid", {63'd0, bus.out_valid}, {63'd0, q.size() > 0});
    if (q.size() > 0) begin
      chk("out_ext", {32'd0, bus.out_ext}, {32'd0, q[0][DW-1:0]});
      chk("out_err", {63'd0, bus.out_err}, {63'd0, q[0][DW]});
    end
    chk("err_sticky", {63'd0, bus.err_sticky}, {63'd0, sticky});
    acc = v && (q.size() < 2);
    xf  = (q.size() > 0) && ordy;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (xf) void'(q.pop_front());
      if (acc) begin
        q.push_back(ref_ext(imm, op, pc));
        if (op >= 3'd5) sticky = 1'b1;
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    sticky = 1'b0;
    reset = 1'b1;
    bus.flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_imm = '0;
    bus.in_op = '0;
    bus.in_pc = '0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_ext", {32'd0, bus.out_ext}, 64'd0);
    chk("rst_out_err", {63'd0, bus.out_err}, 64'd0);
    chk("rst_sticky", {63'd0, bus.err_sticky}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    @(negedge clk);
    reset = 1'b0;

    // Basic opcodes and branch targets.
    cycle(1'b1, 16'h8000, 3'd0, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'h8000, 3'd1, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'h1234, 3'd2, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'hFFFF, 3'd3, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'hFFFF, 3'd4, 32'h00003000, 1'b1, 1'b0);
    cycle(1'b1, 16'h0000, 3'd4, 32'hFFFFFFFC, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);

    // Backpressure fills the skid, then drains in order.
    cycle(1'b1, 16'h0001, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0002, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0003, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);

    // Illegal opcode, then a legal one.
    cycle(1'b1, 16'h7FFF, 3'd6, 32'h0, 1'b1, 1'b0);
    cycle(1'b1, 16'h0001, 3'd0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);

    // Flush with both entries held and a fresh (illegal) input alongside.
    cycle(1'b1, 16'h0011, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0022, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0033, 3'd7, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with both entries held.
    cycle(1'b1, 16'h0044, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b1, 16'h0055, 3'd1, 32'h0, 1'b0, 1'b0);
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("arst_in_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("arst_sticky", {63'd0, bus.err_sticky}, 64'd0);
    q.delete();
    sticky = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            16'($urandom),
            3'($urandom_range(0, 7)),
            32'($urandom),
            1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 19) == 0));
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 16'h0, 3'd0, 32'h0, 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
